note_lane_shifter: RTL and testbench
====================================

# note_lane_shifter

Parametrised multi-lane note shifter for the rhythm-game playfield. Each lane is a WIDTH-bit shift register that scrolls notes toward a hit window at bit 0 on an internal tick. The block adds the following over a plain load/shift register:
- player strikes consume notes inside the window;
- each strike and each note leaving the window is judged (ok / bad / miss);
- a running combo count is kept.

It sits between the chart loader (parallel load / serial feed) and the renderer/scoring logic (lanes_out, judgement pulses).

## Interface
- WIDTH, 100: bits per lane; bit WIDTH-1 is newest, bit 0 is the oldest note.
- LANES, 2: number of independent lanes.
- WINDOW, 5: hit window is bits [WINDOW-1:0]; 1 ≤ WINDOW ≤ WIDTH.
- TICK_DIV, 500000: clock cycles per shift; must be ≥ 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  high: tick counter runs; low: counter holds and no shifts occur.
- load  in  1  synchronous parallel load, active-high.
- load_val  in  LANES*WIDTH  load data; lane k = [k*WIDTH +: WIDTH].
- serial_in  in  LANES  bit entering bit WIDTH-1 of each lane on shift.
- hit  in  LANES  player strike, sampled each edge; one cycle per strike.
- lanes_out  out  LANES*WIDTH  registered lane contents.
- tick  out  1  one-cycle pulse, the cycle after a shift edge.
- hit_ok  out  LANES  one-cycle pulse: the strike consumed a note.
- hit_bad  out  LANES  one-cycle pulse: the strike found no note in the window.
- miss  out  LANES  one-cycle pulse: an unconsumed note shifted out of bit 0.
- combo  out  8  consecutive-success count, saturating at 255.

## Operation
- Tick counter is `$clog2(TICK_DIV)` bits wide. shift_now = enable && cnt == TICK_DIV-1.
  - Counter wraps to 0 on shift_now.
  - Counter increments when enable is high and holds when enable is low.
- Per-edge priority: reset > load > (hit clear, then shift).
- Load cycle:
  - lane ← load_val; cnt ← 0; combo ← 0.
  - All pulses are 0 on the next cycle; hit and shift are ignored that edge.
- Hit on lane k (load low):
  - w = lane[WINDOW-1:0]. If w ≠ 0, clear the lowest set bit of w (oldest note) and set hit_ok[k].
  - If w = 0, the lane is unchanged and hit_bad[k] is set.
- Shift (shift_now, load low): per lane, operates on the post-clear value c.
  - miss[k] = c[0].
  - lane ← {serial_in[k], c[WIDTH-1:1]}.
  - tick is set.
- A hit on the same edge as a shift that clears bit 0 yields hit_ok and no miss.
- Combo update each non-load edge:
  - If any hit_bad or miss is generated on that edge, combo ← 0. Clear wins over increment.
  - Otherwise combo ← min(255, combo + number of lanes with hit_ok).
- Hits are processed when enable is low; only shifting stops.
- Lanes are fully independent except for the shared counter, tick and combo.

## Timing
- Reset values (asynchronous): lanes_out=0, cnt=0, tick=0, hit_ok=0, hit_bad=0, miss=0, combo=0.
- Deassertion of reset takes effect at the next rising edge; a reset mid-shift or mid-hit discards that event.
- All outputs are registered. An event sampled at edge N is visible from N+1 through the end of that cycle:
  - lanes_out update;
  - judgement pulse;
  - combo update.
- Pulses last exactly one cycle. Back-to-back hits on consecutive cycles are each judged independently.
- Shift period is exactly TICK_DIV cycles while enable stays high. The first shift after reset or load occurs TICK_DIV edges later.
- Deasserting enable pauses the phase; reasserting resumes from the held count.

## Test plan
All scenarios use WIDTH=8, LANES=2, WINDOW=3, TICK_DIV=4.
- Shift/miss: load lane0=8'b1000_0001, enable=1, serial_in=0.
  - Required: 4th edge → lane0=8'b0100_0000, tick=1, miss[0]=1, combo=0.
  - Next shift after 4 more edges.
- Hit sequence, enable=0: lane0=8'b0000_0110.
  - hit[0] → lane0=8'b0000_0100, hit_ok[0], combo=1.
  - hit[0] → 8'b0000_0000, combo=2.
  - hit[0] → hit_bad[0], combo=0.
- Outside window: lane0=8'b0000_1000, hit[0] → hit_bad[0]; lane0 unchanged.
- Simultaneous: lane0=8'b0000_0001, hit[0] on the shift edge.
  - Required: lane0=8'b0000_0000, hit_ok[0]=1, miss[0]=0, combo+1.
- Dual lane / saturation: combo=254, both lanes hit_ok on the same edge → combo=255. Further hit_ok holds 255.
- Reset mid-operation: assert reset asynchronously at cnt=2 with lanes nonzero.
  - Required: all outputs 0 immediately.
  - After release, first tick exactly 4 edges later.
- Load priority: assert load and hit on the same edge → lanes = load_val, no hit_ok/hit_bad, cnt=0.

Source files
------------

// File: rtl/note_lane_shifter.sv
// note_lane_shifter: multi-lane rhythm-game note scroller.
// Each lane is a shift register whose oldest note sits at bit 0. Player
// strikes consume the oldest note inside the hit window [WINDOW-1:0].
// Strikes and notes leaving bit 0 are judged as ok / bad / miss, and a
// saturating combo count is kept. Every output is registered.
module note_lane_shifter #(
    parameter int WIDTH    = 100,
    parameter int LANES    = 2,
    parameter int WINDOW   = 5,
    parameter int TICK_DIV = 500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] load_val,
    input  logic [LANES-1:0]       serial_in,
    input  logic [LANES-1:0]       hit,
    output logic [LANES*WIDTH-1:0] lanes_out,
    output logic                   tick,
    output logic [LANES-1:0]       hit_ok,
    output logic [LANES-1:0]       hit_bad,
    output logic [LANES-1:0]       miss,
    output logic [7:0]             combo
);

    localparam int                CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [LANES*WIDTH-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic [LANES-1:0]       hit_ok_q, hit_ok_d;
    logic [LANES-1:0]       hit_bad_q, hit_bad_d;
    logic [LANES-1:0]       miss_q, miss_d;
    logic [7:0]             combo_q, combo_d;

    logic                   shift_now;
    logic [WIDTH-1:0]       lane_v;
    logic [WINDOW-1:0]      win_v;
    int                     ok_count;
    int                     combo_sum;

    assign shift_now = enable && (cnt_q == CNT_MAX);

    // Next-state: load beats everything; otherwise strike clear, then shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lanes_d   = lanes_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        hit_ok_d  = '0;
        hit_bad_d = '0;
        miss_d    = '0;
        combo_d   = combo_q;
        lane_v    = '0;
        win_v     = '0;
        ok_count  = 0;
        combo_sum = 0;

        if (load) begin
            lanes_d = load_val;
            cnt_d   = '0;
            combo_d = '0;
        end else begin
            if (enable) begin
                cnt_d = shift_now ? '0 : cnt_q + 1'b1;
            end
            tick_d = shift_now;

            for (int k = 0; k < LANES; k++) begin
                lane_v = lanes_q[k*WIDTH +: WIDTH];
                win_v  = lane_v[WINDOW-1:0];

                // Strike: drop the oldest note in the window, if any.
                if (hit[k]) begin
                    if (win_v != '0) begin
                        lane_v[WINDOW-1:0] = win_v & (win_v - 1'b1);
                        hit_ok_d[k]        = 1'b1;
                        ok_count           = ok_count + 1;
                    end else begin
                        hit_bad_d[k] = 1'b1;
                    end
                end

                // Shift works on the post-strike lane, so a note struck on
                // the shift edge is never reported as a miss.
                if (shift_now) begin
                    miss_d[k]         = lane_v[0];
                    lane_v            = lane_v >> 1;
                    lane_v[WIDTH-1]   = serial_in[k];
                end

                lanes_d[k*WIDTH +: WIDTH] = lane_v;
            end

            // Any failure on this edge breaks the combo, even if another
            // lane succeeded on the same edge.
            if ((|hit_bad_d) || (|miss_d)) begin
                combo_d = '0;
            end else begin
                combo_sum = int'(combo_q) + ok_count;
                combo_d   = (combo_sum > 255) ? 8'd255 : 8'(combo_sum);
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            lanes_q   <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            hit_ok_q  <= '0;
            hit_bad_q <= '0;
            miss_q    <= '0;
            combo_q   <= '0;
        end else begin
            lanes_q   <= lanes_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            hit_ok_q  <= hit_ok_d;
            hit_bad_q <= hit_bad_d;
            miss_q    <= miss_d;
            combo_q   <= combo_d;
        end
    end

    assign lanes_out = lanes_q;
    assign tick      = tick_q;
    assign hit_ok    = hit_ok_q;
    assign hit_bad   = hit_bad_q;
    assign miss      = miss_q;
    assign combo     = combo_q;

endmodule

// File: tb/tb_note_lane_shifter.sv
// Bench for note_lane_shifter with WIDTH=8, LANES=2, WINDOW=3, TICK_DIV=4.
// A vector table covers one edge per row; hand-written sequences cover
// combo saturation and an asynchronous reset in the middle of a shift period.
module tb_note_lane_shifter;

    localparam int W   = 8;
    localparam int L   = 2;
    localparam int WIN = 3;
    localparam int TD  = 4;
    localparam int NV  = 35;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             load;
    logic [L*W-1:0]   load_val;
    logic [L-1:0]     serial_in;
    logic [L-1:0]     hit;
    logic [L*W-1:0]   lanes_out;
    logic             tick;
    logic [L-1:0]     hit_ok;
    logic [L-1:0]     hit_bad;
    logic [L-1:0]     miss;
    logic [7:0]       combo;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic [1:0]  si;
        logic [1:0]  h;
        logic [15:0] e_lanes;
        logic        e_tick;
        logic [1:0]  e_ok;
        logic [1:0]  e_bad;
        logic [1:0]  e_miss;
        logic [7:0]  e_combo;
    } vec_t;

    vec_t vecs [NV];

    note_lane_shifter #(
        .WIDTH   (W),
        .LANES   (L),
        .WINDOW  (WIN),
        .TICK_DIV(TD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .load_val (load_val),
        .serial_in(serial_in),
        .hit      (hit),
        .lanes_out(lanes_out),
        .tick     (tick),
        .hit_ok   (hit_ok),
        .hit_bad  (hit_bad),
        .miss     (miss),
        .combo    (combo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_lanes, input logic e_tick,
                             input logic [1:0] e_ok, input logic [1:0] e_bad,
                             input logic [1:0] e_miss, input logic [7:0] e_combo);
        check({tag, " lanes"},   32'(lanes_out), 32'(e_lanes));
        check({tag, " tick"},    32'(tick),      32'(e_tick));
        check({tag, " hit_ok"},  32'(hit_ok),    32'(e_ok));
        check({tag, " hit_bad"}, 32'(hit_bad),   32'(e_bad));
        check({tag, " miss"},    32'(miss),      32'(e_miss));
        check({tag, " combo"},   32'(combo),     32'(e_combo));
    endtask

    initial begin
        //           ld    lv        en    si     h      lanes     tk    ok     bad    miss   combo
        // Shift / miss: first shift 4 edges after load, then every 4.
        vecs[0]  = '{1'b1, 16'h0081, 1'b1, 2'b00, 2'b00, 16'h0081, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0081, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0081, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0081, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0040, 1'b1, 2'b00, 2'b00, 2'b01, 8'd0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0040, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0040, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0040, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0020, 1'b1, 2'b00, 2'b00, 2'b00, 8'd0};
        // Hit sequence with enable low.
        vecs[9]  = '{1'b1, 16'h0006, 1'b0, 2'b00, 2'b00, 16'h0006, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b01, 16'h0004, 1'b0, 2'b01, 2'b00, 2'b00, 8'd1};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b01, 16'h0000, 1'b0, 2'b01, 2'b00, 2'b00, 8'd2};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b01, 16'h0000, 1'b0, 2'b00, 2'b01, 2'b00, 8'd0};
        // Note outside the window.
        vecs[13] = '{1'b1, 16'h0008, 1'b0, 2'b00, 2'b00, 16'h0008, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b01, 16'h0008, 1'b0, 2'b00, 2'b01, 2'b00, 8'd0};
        // Dual lane: combo +2 per edge, then a bad on lane 1 clears it.
        vecs[15] = '{1'b1, 16'h0507, 1'b0, 2'b00, 2'b00, 16'h0507, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b11, 16'h0406, 1'b0, 2'b11, 2'b00, 2'b00, 8'd2};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b11, 16'h0004, 1'b0, 2'b11, 2'b00, 2'b00, 8'd4};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b11, 16'h0000, 1'b0, 2'b01, 2'b10, 2'b00, 8'd0};
        // Hit on the shift edge consumes bit 0: ok, no miss; lane 1 takes serial_in.
        vecs[19] = '{1'b1, 16'h0001, 1'b1, 2'b00, 2'b00, 16'h0001, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[20] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0001, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[21] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0001, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[22] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0001, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[23] = '{1'b0, 16'h0000, 1'b1, 2'b10, 2'b01, 16'h8000, 1'b1, 2'b01, 2'b00, 2'b00, 8'd1};
        // Enable pauses the phase: six edges, four of them enabled.
        vecs[24] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h8000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1};
        vecs[25] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h8000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1};
        vecs[26] = '{1'b0, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h8000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1};
        vecs[27] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h8000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1};
        vecs[28] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h8000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd1};
        vecs[29] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h4000, 1'b1, 2'b00, 2'b00, 2'b00, 8'd1};
        // Load beats hit; counter restarts so the next shift is 4 edges later.
        vecs[30] = '{1'b1, 16'h0203, 1'b1, 2'b00, 2'b11, 16'h0203, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[31] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0203, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[32] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0203, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[33] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0203, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0};
        vecs[34] = '{1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 16'h0101, 1'b1, 2'b00, 2'b00, 2'b01, 8'd0};

        // Reset state.
        reset     = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        serial_in = '0;
        hit       = '0;
        #12;
        check_all("reset", 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven vectors, one edge each.
        for (int i = 0; i < NV; i++) begin
            load      = vecs[i].ld;
            load_val  = vecs[i].lv;
            enable    = vecs[i].en;
            serial_in = vecs[i].si;
            hit       = vecs[i].h;
            step();
            check_all($sformatf("v%0d", i), vecs[i].e_lanes, vecs[i].e_tick, vecs[i].e_ok,
                      vecs[i].e_bad, vecs[i].e_miss, vecs[i].e_combo);
        end

        // Combo saturation: full lanes refilled by serial_in, both lanes struck
        // on every shift edge, so combo climbs by 2 per period up to 255.
        load      = 1'b1;
        load_val  = 16'hFFFF;
        enable    = 1'b1;
        serial_in = 2'b11;
        hit       = 2'b00;
        step();
        load = 1'b0;
        check("sat load combo", 32'(combo), 32'd0);
        for (int p = 1; p <= 129; p++) begin
            hit = 2'b00;
            repeat (TD - 1) step();
            hit = 2'b11;
            step();
            check($sformatf("sat p%0d combo", p), 32'(combo), (2 * p > 255) ? 32'd255 : 32'(2 * p));
            if (p >= 127) begin
                check_all($sformatf("sat p%0d", p), 16'hFFFF, 1'b1, 2'b11, 2'b00, 2'b00,
                          (2 * p > 255) ? 8'd255 : 8'(2 * p));
            end
        end
        hit = 2'b00;

        // Asynchronous reset two edges into a shift period.
        load      = 1'b1;
        load_val  = 16'h3C3C;
        serial_in = 2'b00;
        step();
        load = 1'b0;
        step();
        step();
        check("pre-reset lanes", 32'(lanes_out), 32'h3C3C);
        #3;
        reset = 1'b1;
        #1;
        check_all("async reset", 16'h0000, 1'b0, 2'b00, 2'b00, 2'b00, 8'd0);
        @(negedge clock);
        reset     = 1'b0;
        serial_in = 2'b01;
        for (int e = 1; e <= TD; e++) begin
            step();
            check($sformatf("post-reset e%0d tick", e), 32'(tick), (e == TD) ? 32'd1 : 32'd0);
        end
        check("post-reset lanes", 32'(lanes_out), 32'h0080);
        check("post-reset combo", 32'(combo), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
